sync_line_buf_fifo: RTL and testbench



---
 rtl/sync_line_buf_pkg.sv | 16 +
 rtl/sync_line_buf_ram.sv | 26 ++
 rtl/sync_line_buf_fifo.sv | 153 +++++++++++++++
 tb/tb_sync_line_buf_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_line_buf_pkg.sv
// sync_line_buf_pkg: read-mode constants and parameter helpers for the line-buffer FIFO.
package sync_line_buf_pkg;
  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;
  function automatic int ptr_width(input int depth_w);
    return depth_w + 1;
  endfunction
  function automatic int level_width(input int depth_w);
    return depth_w + 1;
  endfunction
  function automatic bit params_legal(input int data_w, input int depth_w, input int line_len,
                                      input int af, input int ae);
    return data_w >= 1 && line_len >= 1 && line_len <= (1 << depth_w) && ae < af &&
           af <= (1 << depth_w);
  endfunction
endpackage

// File: rtl/sync_line_buf_ram.sv
// sync_line_buf_ram: simple dual-port RAM with an enable-gated registered read port.
module sync_line_buf_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);
  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  // The read register doubles as the FWFT prefetch stage, so flush clears it too
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (clr_i) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_line_buf_fifo.sv
// sync_line_buf_fifo: single-clock line-buffer FIFO, standard or FWFT read, line accounting.
// Defining SYNC_LINE_BUF_PARITY_EN adds a RAM parity bit with rd_par_err/par_err outputs.
module sync_line_buf_fifo
  import sync_line_buf_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int DEPTH_WIDTH      = 11,
  parameter int LINE_LEN         = 1280,
  parameter int FWFT             = FWFT_OFF,
  parameter int ALMOST_FULL_NUM  = 2040,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  wr_full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_eol,
  output logic                  rd_empty,
  output logic                  almost_empty,
  output logic [DEPTH_WIDTH:0]  water_level,
  output logic [DEPTH_WIDTH:0]  lines_avail,
  output logic                  overflow,
  output logic                  underflow
`ifdef SYNC_LINE_BUF_PARITY_EN
  ,
  output logic                  rd_par_err,
  output logic                  par_err
`endif
);
  localparam int PW = ptr_width(DEPTH_WIDTH);
  localparam int LW = level_width(DEPTH_WIDTH);
`ifdef SYNC_LINE_BUF_PARITY_EN
  localparam int RW = DATA_WIDTH + 1;
`else
  localparam int RW = DATA_WIDTH;
`endif
  localparam bit IS_FWFT = FWFT == FWFT_ON;
  localparam logic [PW-1:0] COL_LAST = PW'(LINE_LEN - 1);
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {DEPTH_WIDTH{1'b0}}};

  if (!params_legal(DATA_WIDTH, DEPTH_WIDTH, LINE_LEN, ALMOST_FULL_NUM, ALMOST_EMPTY_NUM))
  begin : g_illegal
    $error("sync_line_buf_fifo: illegal parameter set");
  end

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wcol_q, wcol_d, rcol_q, rcol_d;
  logic [LW-1:0] level_q, level_d, lines_q, lines_d;
  logic full_q, full_d, empty_q, empty_d, afull_q, afull_d, aempty_q, aempty_d;
  logic ovf_q, ovf_d, unf_q, unf_d, vld_q, vld_d, eol_q, eol_d;
  logic wr_acc, rd_ok, pop, ram_re, wline, rline;
  logic [RW-1:0] ram_wdata, ram_rdata;

  // In FWFT mode the RAM is read whenever the head slot is empty or being popped
  always_comb begin
    wr_acc   = wr_en && !full_q && !flush;
    rd_ok    = IS_FWFT ? vld_q : !empty_q;
    pop      = rd_en && rd_ok && !flush;
    ram_re   = IS_FWFT ? !empty_q && (!vld_q || rd_en) && !flush : pop;
    wline    = wr_acc && wcol_q == COL_LAST;
    rline    = pop && rcol_q == COL_LAST;
    wptr_d   = flush ? '0 : wptr_q + PW'(wr_acc);
    rptr_d   = flush ? '0 : rptr_q + PW'(ram_re);
    level_d  = flush ? '0 : level_q + LW'(wr_acc) - LW'(pop);
    lines_d  = flush ? '0 : lines_q + LW'(wline) - LW'(rline);
    wcol_d   = flush || wline ? '0 : wcol_q + PW'(wr_acc);
    rcol_d   = flush || rline ? '0 : rcol_q + PW'(pop);
    full_d   = (wptr_d ^ rptr_d) == FULL_XOR;
    empty_d  = wptr_d == rptr_d;
    afull_d  = level_d >= LW'(ALMOST_FULL_NUM);
    aempty_d = level_d <= LW'(ALMOST_EMPTY_NUM);
    ovf_d    = !flush && (ovf_q || (wr_en && full_q));
    unf_d    = !flush && (unf_q || (rd_en && !rd_ok));
    vld_d    = IS_FWFT ? ram_re || (vld_q && !rd_en && !flush) : pop;
    eol_d    = rline;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      wcol_q   <= '0;
      rcol_q   <= '0;
      level_q  <= '0;
      lines_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      vld_q    <= 1'b0;
      eol_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      wcol_q   <= wcol_d;
      rcol_q   <= rcol_d;
      level_q  <= level_d;
      lines_q  <= lines_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      vld_q    <= vld_d;
      eol_q    <= eol_d;
    end
  end

`ifdef SYNC_LINE_BUF_PARITY_EN
  logic par_q;
  assign ram_wdata  = {^wr_data, wr_data};
  assign rd_par_err = vld_q && ^ram_rdata;
  assign par_err    = par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else par_q <= !flush && (par_q || rd_par_err);
  end
`else
  assign ram_wdata = wr_data;
`endif

  sync_line_buf_ram #(.WIDTH(RW), .ADDR_W(DEPTH_WIDTH)) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (flush),
    .we_i   (wr_acc),
    .waddr_i(wptr_q[DEPTH_WIDTH-1:0]),
    .wdata_i(ram_wdata),
    .re_i   (ram_re),
    .raddr_i(rptr_q[DEPTH_WIDTH-1:0]),
    .rdata_o(ram_rdata)
  );

  assign wr_full      = full_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign water_level  = level_q;
  assign lines_avail  = lines_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign rd_valid     = vld_q;
  assign rd_empty     = IS_FWFT ? !vld_q : empty_q;
  assign rd_eol       = IS_FWFT ? vld_q && rcol_q == COL_LAST : eol_q;
  assign rd_data      = ram_rdata[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_sync_line_buf_fifo.sv
// tb_sync_line_buf_fifo: vector table, corner sequences and a queue model for both read modes.
module tb_sync_line_buf_fifo;
  localparam int DW = 8, AW = 3, LL = 4, AF = 6, AE = 2, DEPTH = 8;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic s_full, s_af, s_vld, s_eol, s_empty, s_ae, s_ovf, s_unf;
  logic f_full, f_af, f_vld, f_eol, f_empty, f_ae, f_ovf, f_unf;
  logic [DW-1:0] s_data, f_data;
  logic [AW:0] s_lvl, s_lines, f_lvl, f_lines;
`ifdef SYNC_LINE_BUF_PARITY_EN
  logic s_rpe, s_pe, f_rpe, f_pe;
`endif
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  sync_line_buf_fifo #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .LINE_LEN(LL), .FWFT(0),
                       .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
    .wr_full(s_full), .almost_full(s_af), .rd_en(rd_en), .rd_data(s_data),
    .rd_valid(s_vld), .rd_eol(s_eol), .rd_empty(s_empty), .almost_empty(s_ae),
    .water_level(s_lvl), .lines_avail(s_lines), .overflow(s_ovf), .underflow(s_unf)
`ifdef SYNC_LINE_BUF_PARITY_EN
    , .rd_par_err(s_rpe), .par_err(s_pe)
`endif
  );

  sync_line_buf_fifo #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .LINE_LEN(LL), .FWFT(1),
                       .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)) u_fw (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
    .wr_full(f_full), .almost_full(f_af), .rd_en(rd_en), .rd_data(f_data),
    .rd_valid(f_vld), .rd_eol(f_eol), .rd_empty(f_empty), .almost_empty(f_ae),
    .water_level(f_lvl), .lines_avail(f_lines), .overflow(f_ovf), .underflow(f_unf)
`ifdef SYNC_LINE_BUF_PARITY_EN
    , .rd_par_err(f_rpe), .par_err(f_pe)
`endif
  );

  typedef struct {
    bit f, w, r;
    logic [7:0] d;
    int lvl;
    bit full, empty, ovf, unf;
    int lines;
    bit vld;
    logic [7:0] dat;
    bit eol;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit f, input bit w, input bit r, input logic [7:0] d);
    flush = f; wr_en = w; rd_en = r; wr_data = d;
    @(posedge clk); #1;
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  logic [7:0] q[$];
  bit m_ovf, m_unf;
  int m_wcol, m_rcol, m_lines;

  initial begin
    vt[0]  = '{0,1,1,8'h11, 1,0,0,0,1, 0, 0,8'h00,0};
    vt[1]  = '{0,1,0,8'h22, 2,0,0,0,1, 0, 0,8'h00,0};
    vt[2]  = '{1,1,1,8'h33, 0,0,1,0,0, 0, 0,8'h00,0};
    vt[3]  = '{0,0,1,8'h00, 0,0,1,0,1, 0, 0,8'h00,0};
    vt[4]  = '{0,1,0,8'h01, 1,0,0,0,1, 0, 0,8'h00,0};
    vt[5]  = '{0,1,0,8'h02, 2,0,0,0,1, 0, 0,8'h00,0};
    vt[6]  = '{0,1,0,8'h03, 3,0,0,0,1, 0, 0,8'h00,0};
    vt[7]  = '{0,1,0,8'h04, 4,0,0,0,1, 1, 0,8'h00,0};
    vt[8]  = '{0,1,1,8'h05, 4,0,0,0,1, 1, 1,8'h01,0};
    vt[9]  = '{0,0,1,8'h00, 3,0,0,0,1, 1, 1,8'h02,0};
    vt[10] = '{0,0,1,8'h00, 2,0,0,0,1, 1, 1,8'h03,0};
    vt[11] = '{0,0,1,8'h00, 1,0,0,0,1, 0, 1,8'h04,1};
    vt[12] = '{1,0,0,8'h00, 0,0,1,0,0, 0, 0,8'h00,0};

    #12;
    chk("rst.lvl", s_lvl, 0); chk("rst.empty", s_empty, 1); chk("rst.aempty", s_ae, 1);
    chk("rst.full", s_full, 0); chk("rst.vld", s_vld, 0); chk("rst.data", s_data, 0);
    chk("rst.fw_empty", f_empty, 1); chk("rst.fw_vld", f_vld, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      cyc(vt[i].f, vt[i].w, vt[i].r, vt[i].d);
      chk($sformatf("vec%0d.lvl", i), s_lvl, vt[i].lvl);
      chk($sformatf("vec%0d.full", i), s_full, vt[i].full);
      chk($sformatf("vec%0d.empty", i), s_empty, vt[i].empty);
      chk($sformatf("vec%0d.ovf", i), s_ovf, vt[i].ovf);
      chk($sformatf("vec%0d.unf", i), s_unf, vt[i].unf);
      chk($sformatf("vec%0d.lines", i), s_lines, vt[i].lines);
      chk($sformatf("vec%0d.vld", i), s_vld, vt[i].vld);
      chk($sformatf("vec%0d.eol", i), s_eol, vt[i].eol);
      if (vt[i].vld) chk($sformatf("vec%0d.data", i), s_data, vt[i].dat);
    end

    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 8'(i));
    chk("fill.full", s_full, 1); chk("fill.lvl", s_lvl, 8); chk("fill.af", s_af, 1);
    chk("fill.lines", s_lines, 2);
    cyc(0, 1, 0, 8'hEE);
    chk("ovf.flag", s_ovf, 1); chk("ovf.lvl", s_lvl, 8);
    cyc(0, 1, 1, 8'h77);
    chk("fullrw.vld", s_vld, 1); chk("fullrw.data", s_data, 0); chk("fullrw.lvl", s_lvl, 7);
    chk("fullrw.full", s_full, 0); chk("fullrw.ovf", s_ovf, 1);
    for (int i = 1; i < 8; i++) begin
      cyc(0, 0, 1, 8'h00);
      chk($sformatf("drain%0d.data", i), s_data, i);
      chk($sformatf("drain%0d.eol", i), s_eol, int'(i % 4 == 3));
    end
    chk("drain.empty", s_empty, 1); chk("drain.lvl", s_lvl, 0); chk("drain.lines", s_lines, 0);
    cyc(0, 1, 1, 8'h5A);
    chk("emptyrw.unf", s_unf, 1); chk("emptyrw.lvl", s_lvl, 1); chk("emptyrw.vld", s_vld, 0);
    cyc(1, 1, 1, 8'hFF);
    chk("flush.lvl", s_lvl, 0); chk("flush.lines", s_lines, 0); chk("flush.empty", s_empty, 1);
    chk("flush.ovf", s_ovf, 0); chk("flush.unf", s_unf, 0);

    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 8'(8'h40 + i));
    cyc(0, 0, 1, 8'h00); chk("line.eol0", s_eol, 0);
    cyc(0, 0, 1, 8'h00); chk("line.eol1", s_eol, 0);
    cyc(0, 1, 0, 8'h48); cyc(0, 1, 0, 8'h49);
    chk("line.lines10", s_lines, 2);
    cyc(0, 0, 1, 8'h00); chk("line.eol2", s_eol, 0);
    cyc(0, 0, 1, 8'h00); chk("line.eol3", s_eol, 1); chk("line.data3", s_data, 8'h43);
    chk("line.lines", s_lines, 1);

    wr_en = 1'b1; wr_data = 8'h3C; rd_en = 1'b1; flush = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0; #1;
    chk("arst.lvl", s_lvl, 0); chk("arst.lines", s_lines, 0); chk("arst.empty", s_empty, 1);
    chk("arst.ovf", s_ovf, 0); chk("arst.unf", s_unf, 0); chk("arst.aempty", s_ae, 1);
    wr_en = 1'b0; rd_en = 1'b0; #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst.idle_lvl", s_lvl, 0);

    q.delete(); m_ovf = 0; m_unf = 0; m_wcol = 0; m_rcol = 0; m_lines = 0;
    for (int i = 0; i < 400; i++) begin
      bit f, w, r, e_vld, e_eol, pre_full, pre_empty;
      logic [7:0] d, e_dat;
      f = $urandom_range(0, 49) == 0;
      w = $urandom_range(0, 99) < (i < 200 ? 75 : 30);
      r = $urandom_range(0, 99) < (i < 200 ? 30 : 75);
      d = 8'($urandom);
      e_vld = 0; e_eol = 0; e_dat = 8'h00;
      pre_full = q.size() == DEPTH;
      pre_empty = q.size() == 0;
      if (f) begin
        q.delete(); m_ovf = 0; m_unf = 0; m_wcol = 0; m_rcol = 0; m_lines = 0;
      end else begin
        if (r && pre_empty) m_unf = 1;
        else if (r) begin
          e_dat = q.pop_front(); e_vld = 1; e_eol = m_rcol == LL - 1;
          if (e_eol) m_lines--;
          m_rcol = (m_rcol + 1) % LL;
        end
        if (w && pre_full) m_ovf = 1;
        else if (w) begin
          q.push_back(d);
          m_wcol++;
          if (m_wcol == LL) begin m_wcol = 0; m_lines++; end
        end
      end
      cyc(f, w, r, d);
      chk($sformatf("rnd%0d.lvl", i), s_lvl, q.size());
      chk($sformatf("rnd%0d.full", i), s_full, int'(q.size() == DEPTH));
      chk($sformatf("rnd%0d.empty", i), s_empty, int'(q.size() == 0));
      chk($sformatf("rnd%0d.af", i), s_af, int'(q.size() >= AF));
      chk($sformatf("rnd%0d.ae", i), s_ae, int'(q.size() <= AE));
      chk($sformatf("rnd%0d.ovf", i), s_ovf, m_ovf);
      chk($sformatf("rnd%0d.unf", i), s_unf, m_unf);
      chk($sformatf("rnd%0d.lines", i), s_lines, m_lines);
      chk($sformatf("rnd%0d.vld", i), s_vld, e_vld);
      chk($sformatf("rnd%0d.eol", i), s_eol, e_eol);
      if (e_vld) chk($sformatf("rnd%0d.data", i), s_data, e_dat);
    end

    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'hA5);
    chk("fw.vld1", f_vld, 0); chk("fw.lvl1", f_lvl, 1); chk("fw.empty1", f_empty, 1);
    cyc(0, 0, 0, 8'h00);
    chk("fw.vld2", f_vld, 1); chk("fw.data2", f_data, 8'hA5); chk("fw.empty2", f_empty, 0);
    cyc(0, 0, 1, 8'h00);
    chk("fw.pop_empty", f_empty, 1); chk("fw.pop_lvl", f_lvl, 0);
    cyc(0, 0, 1, 8'h00);
    chk("fw.unf", f_unf, 1);
    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'(8'h10 + i));
    chk("fw.lvl4", f_lvl, 4); chk("fw.lines4", f_lines, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fw.head%0d", i), f_data, 8'h10 + i);
      chk($sformatf("fw.hvld%0d", i), f_vld, 1);
      chk($sformatf("fw.heol%0d", i), f_eol, int'(i == 3));
      cyc(0, 0, 1, 8'h00);
    end
    chk("fw.b2b_empty", f_empty, 1); chk("fw.b2b_lines", f_lines, 0);
    chk("fw.b2b_unf", f_unf, 0);

`ifdef SYNC_LINE_BUF_PARITY_EN
    cyc(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'(8'h20 + i));
    u_std.u_ram.mem_q[2][DW] = ~u_std.u_ram.mem_q[2][DW];
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 8'h00);
      chk($sformatf("par%0d.rpe", i), s_rpe, int'(i == 2));
      chk($sformatf("par%0d.sticky", i), s_pe, int'(i >= 3));
    end
    cyc(1, 0, 0, 8'h00);
    chk("par.flush", s_pe, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
